// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: fetch from IMEM, decode immediate/format, hold for execute handshake.
// Optional ILLEGAL_TRAP_EN macro adds a FAULT state entered after an illegal instruction is accepted.
module instr_fetch_sequencer #(
    parameter int unsigned      Width    = 32,
    parameter logic [Width-1:0] RESET_PC = Width'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [Width-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [Width-1:0] imem_rdata,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [Width-1:0] dec_instr,
    output logic [Width-1:0] dec_imm,
    output logic [2:0]       dec_fmt,
    output logic [Width-1:0] dec_pc,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_pc
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        HOLD
`ifdef ILLEGAL_TRAP_EN
        , FAULT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [Width-1:0]   pc_q, pc_d;
    logic [Width-1:0]   ir_q;
    logic               ir_load, dec_load;
    logic [31:0]        word;
    logic signed [31:0] imm32;
    logic [2:0]         fmt_c;

    assign imem_addr = pc_q;
    assign word      = ir_q[31:0];

    // Next-state and load strobes; a redirect overrides everything outside IDLE
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_load  = 1'b0;
        dec_load = 1'b0;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                dec_load = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (dec_ready) begin
                    pc_d    = pc_q + Width'(4);
                    state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
                    if (dec_fmt == FMT_ILL) begin
                        pc_d    = pc_q;
                        state_d = FAULT;
                    end
`endif
                end
            end
`ifdef ILLEGAL_TRAP_EN
            FAULT:  state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
        if (redirect_valid && (state_q != IDLE)) begin
            state_d  = FETCH;
            pc_d     = redirect_pc;
            ir_load  = 1'b0;
            dec_load = 1'b0;
        end
    end

    // Immediate extraction and format classification by opcode
    always_comb begin
        imm32 = '0;
        fmt_c = FMT_ILL;
        case (word[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                imm32 = {{20{word[31]}}, word[31:20]};
                fmt_c = FMT_I;
            end
            7'b0100011: begin
                imm32 = {{20{word[31]}}, word[31:25], word[11:7]};
                fmt_c = FMT_S;
            end
            7'b1100011: begin
                imm32 = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
                fmt_c = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                imm32 = {word[31:12], 12'b0};
                fmt_c = FMT_U;
            end
            7'b1101111: begin
                imm32 = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
                fmt_c = FMT_J;
            end
            7'b0110011: begin
                imm32 = '0;
                fmt_c = FMT_R;
            end
            default: begin
                imm32 = '0;
                fmt_c = FMT_ILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            imem_req  <= 1'b0;
            dec_valid <= 1'b0;
            dec_instr <= '0;
            dec_imm   <= '0;
            dec_fmt   <= FMT_R;
            dec_pc    <= '0;
        end else begin
            pc_q      <= pc_d;
            imem_req  <= (state_d == FETCH);
            dec_valid <= (state_d == HOLD);
            if (ir_load) begin
                ir_q <= imem_rdata;
            end
            if (dec_load) begin
                dec_instr <= ir_q;
                dec_imm   <= Width'(imm32);
                dec_fmt   <= fmt_c;
                dec_pc    <= pc_q;
            end
        end
    end

endmodule
